// File: rtl/if_stage_pkg.sv
// ---------------------------------------------------------------------------
// if_stage_pkg
//   Shared definitions for the instruction-fetch stage: bus widths that must
//   agree with the decode stage, the default reset fetch address, the branch
//   bus layout and the sequential next-PC helper.
// ---------------------------------------------------------------------------
package if_stage_pkg;

    localparam int          FS_TO_DS_BUS_WD  = 64;
    localparam int          BR_BUS_WD        = 33;
    localparam int          INST_WD          = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c000000;

    // Field order matches {br_taken, br_target} as driven by decode.
    typedef struct packed {
        logic        taken;
        logic [31:0] target;
    } br_bus_t;

    // Sequential successor of a fetch address; wraps at 32 bits.
    function automatic logic [31:0] seq_pc_of(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_stage_fs_inst_skid.sv
// ---------------------------------------------------------------------------
// fs_inst_skid
//   One-entry holding buffer for instruction SRAM read data. The SRAM only
//   presents read data for a single cycle, so when decode stalls the word is
//   parked here and presented until decode takes it.
//
// Ports
//   clk      clock
//   resetn   synchronous active-low reset
//   capture  store din this cycle (ignored while already holding a word)
//   clear    drop the held word; wins over capture
//   din      raw SRAM read data
//   dout     held word when the buffer is full, otherwise din
// ---------------------------------------------------------------------------
import if_stage_pkg::*;

module fs_inst_skid #(
    parameter int WIDTH = INST_WD
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             capture,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic             buf_valid;
    logic [WIDTH-1:0] inst_buf;

    // Clear is checked first so a redirect or hand-off can never leave a
    // stale word behind, even if a capture is requested in the same cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            buf_valid <= 1'b0;
            inst_buf  <= '0;
        end else if (clear) begin
            buf_valid <= 1'b0;
        end else if (capture && !buf_valid) begin
            buf_valid <= 1'b1;
            inst_buf  <= din;
        end
    end

    assign dout = buf_valid ? inst_buf : din;

endmodule

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage
//   Instruction-fetch stage of the five-stage blocking pipeline. Computes the
//   next fetch address (sequential or branch redirect), issues the request to
//   the synchronous instruction SRAM, holds the IF valid/PC registers and
//   hands {inst, pc} to decode through the fs->ds valid/allowin handshake.
//
// Ports
//   clk              clock
//   resetn           synchronous active-low reset
//   ds_allowin       decode can accept an instruction this cycle
//   br_bus           {br_taken, br_target} from decode
//   fs_to_ds_valid   instruction valid toward decode
//   fs_to_ds_bus     {fs_inst, fs_pc}
//   inst_sram_en     fetch request strobe
//   inst_sram_we     write enables, tied to zero
//   inst_sram_addr   fetch address (nextpc)
//   inst_sram_wdata  write data, tied to zero
//   inst_sram_rdata  read data, valid one cycle after an enabled request
// ---------------------------------------------------------------------------
import if_stage_pkg::*;

module if_stage #(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       ds_allowin,
    input  logic [BR_BUS_WD-1:0]       br_bus,
    output logic                       fs_to_ds_valid,
    output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
    output logic                       inst_sram_en,
    output logic [3:0]                 inst_sram_we,
    output logic [31:0]                inst_sram_addr,
    output logic [31:0]                inst_sram_wdata,
    input  logic [31:0]                inst_sram_rdata
);

    br_bus_t     br;
    logic        br_taken;
    logic [31:0] br_target;

    logic        to_fs_valid;
    logic [31:0] seq_pc;
    logic [31:0] nextpc;

    logic        fs_valid;
    logic [31:0] fs_pc;
    logic        fs_ready_go;
    logic        fs_allowin;
    logic        rdata_fresh;
    logic [31:0] fs_inst;

    logic        skid_capture;
    logic        skid_clear;

    assign br        = br_bus;
    assign br_taken  = br.taken;
    assign br_target = br.target;

    // Pre-IF: always try to fetch once out of reset; a taken branch overrides
    // the sequential address.
    assign to_fs_valid = resetn;
    assign seq_pc      = seq_pc_of(fs_pc);
    assign nextpc      = br_taken ? br_target : seq_pc;

    // A taken branch must be able to redirect even while decode is stalled,
    // because the word currently in IF is wrong-path and will be dropped.
    assign fs_ready_go = 1'b1;
    assign fs_allowin  = !fs_valid || (fs_ready_go && ds_allowin) || br_taken;

    // resetn gating keeps the handshake quiet in the first reset cycle, when
    // fs_valid still holds its pre-reset value.
    assign fs_to_ds_valid = resetn && fs_valid && fs_ready_go && !br_taken;

    assign inst_sram_en    = to_fs_valid && fs_allowin;
    assign inst_sram_addr  = nextpc;
    assign inst_sram_we    = 4'h0;
    assign inst_sram_wdata = 32'h0;

    // rdata_fresh marks the one cycle in which inst_sram_rdata belongs to the
    // instruction sitting in IF; clearing it on reset discards an in-flight
    // response.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            fs_valid    <= 1'b0;
            fs_pc       <= RESET_PC - 32'd4;
            rdata_fresh <= 1'b0;
        end else begin
            rdata_fresh <= inst_sram_en;
            if (fs_allowin) begin
                fs_valid <= to_fs_valid;
                fs_pc    <= nextpc;
            end
        end
    end

    // Park the fresh word when decode refuses it; drop it once it is handed
    // off or when a redirect makes it wrong-path.
    assign skid_capture = rdata_fresh && fs_valid && !ds_allowin && !br_taken;
    assign skid_clear   = (fs_to_ds_valid && ds_allowin) || br_taken;

    fs_inst_skid #(
        .WIDTH (INST_WD)
    ) u_skid (
        .clk     (clk),
        .resetn  (resetn),
        .capture (skid_capture),
        .clear   (skid_clear),
        .din     (inst_sram_rdata),
        .dout    (fs_inst)
    );

    assign fs_to_ds_bus = {fs_inst, fs_pc};

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage
//   Self-checking bench for if_stage. A behavioural SRAM answers every
//   enabled request one cycle later with mem_word(addr) and drives random
//   garbage otherwise. The reference model tracks only "is there an
//   instruction in IF, and at which PC"; the instruction it expects is simply
//   the memory content at that PC.
// ---------------------------------------------------------------------------
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h1c000000;

    logic        clk;
    logic        resetn;
    logic        ds_allowin;
    logic [32:0] br_bus;
    logic        fs_to_ds_valid;
    logic [63:0] fs_to_ds_bus;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;

    int tests_run;
    int tests_failed;

    // Memory content is addr ^ key; key is zero for the directed tests so
    // each instruction word equals its own address.
    logic [31:0] key;

    logic        pend_en;
    logic [31:0] pend_addr;
    logic [31:0] garbage;

    // Reference model state and per-cycle expectations.
    logic        m_valid;
    logic [31:0] m_pc;
    logic        cur_rst;
    logic        exp_allowin;
    logic        exp_valid;
    logic        exp_en;
    logic [31:0] exp_addr;
    logic [63:0] exp_bus;

    if_stage #(.RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .ds_allowin      (ds_allowin),
        .br_bus          (br_bus),
        .fs_to_ds_valid  (fs_to_ds_valid),
        .fs_to_ds_bus    (fs_to_ds_bus),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_we    (inst_sram_we),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ key;
    endfunction

    // Synchronous SRAM: data for a request appears the cycle after it.
    always @(posedge clk) begin
        pend_en   <= inst_sram_en;
        pend_addr <= inst_sram_addr;
        garbage   <= $urandom;
    end

    assign inst_sram_rdata = pend_en ? (pend_addr ^ key) : garbage;

    // Drive one cycle of inputs and derive what the stage must show.
    task automatic apply(input logic rst_n, input logic ain, input logic bt,
                         input logic [31:0] tgt);
        resetn      = rst_n;
        ds_allowin  = ain;
        br_bus      = {bt, tgt};
        cur_rst     = rst_n;
        exp_allowin = !m_valid || ain || bt;
        exp_valid   = rst_n && m_valid && !bt;
        exp_en      = rst_n && exp_allowin;
        exp_addr    = bt ? tgt : m_pc + 32'd4;
        exp_bus     = {mem_word(m_pc), m_pc};
        #4;
    endtask

    // Cross the clock edge and move the model to the next cycle.
    task automatic advance();
        @(posedge clk);
        if (!cur_rst) begin
            m_valid = 1'b0;
            m_pc    = RESET_PC - 32'd4;
        end else if (exp_allowin) begin
            m_valid = 1'b1;
            m_pc    = exp_addr;
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            apply(1'b0, 1'b1, 1'b0, 32'h0);
            tests_run++;
            if (inst_sram_en !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL reset_en: got %b expected 0", inst_sram_en);
            end
            tests_run++;
            if (fs_to_ds_valid !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL reset_valid: got %b expected 0", fs_to_ds_valid);
            end
            tests_run++;
            if (inst_sram_we !== 4'h0 || inst_sram_wdata !== 32'h0) begin
                tests_failed++;
                $display("[TB] FAIL reset_wr_ties: got we=%h wdata=%h expected 0/0",
                         inst_sram_we, inst_sram_wdata);
            end
            advance();
        end
    endtask

    task automatic test_stream_and_stall();
        logic [31:0] pc;
        // First fetch after reset release.
        apply(1'b1, 1'b1, 1'b0, 32'h0);
        tests_run++;
        if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h1c000000 || fs_to_ds_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL first_fetch: got en=%b addr=%h valid=%b expected 1/1c000000/0",
                     inst_sram_en, inst_sram_addr, fs_to_ds_valid);
        end
        advance();
        // One instruction per cycle.
        for (int i = 0; i < 2; i++) begin
            pc = 32'h1c000000 + 32'(4 * i);
            apply(1'b1, 1'b1, 1'b0, 32'h0);
            tests_run++;
            if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus !== {pc, pc} || inst_sram_addr !== pc + 32'd4) begin
                tests_failed++;
                $display("[TB] FAIL stream_%0d: got valid=%b bus=%h addr=%h expected 1/%h/%h",
                         i, fs_to_ds_valid, fs_to_ds_bus, inst_sram_addr, {pc, pc}, pc + 32'd4);
            end
            advance();
        end
        // Decode stalls for three cycles on the instruction at 0x1c000008.
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 1'b0, 1'b0, 32'h0);
            tests_run++;
            if (inst_sram_en !== 1'b0 || fs_to_ds_valid !== 1'b1 ||
                fs_to_ds_bus !== {32'h1c000008, 32'h1c000008}) begin
                tests_failed++;
                $display("[TB] FAIL stall_%0d: got en=%b valid=%b bus=%h expected 0/1/1c0000081c000008",
                         i, inst_sram_en, fs_to_ds_valid, fs_to_ds_bus);
            end
            advance();
        end
        // Release: buffered word handed off, next request is sequential.
        apply(1'b1, 1'b1, 1'b0, 32'h0);
        tests_run++;
        if (fs_to_ds_bus !== {32'h1c000008, 32'h1c000008} || inst_sram_en !== 1'b1 ||
            inst_sram_addr !== 32'h1c00000c) begin
            tests_failed++;
            $display("[TB] FAIL stall_release: got bus=%h en=%b addr=%h expected 1c0000081c000008/1/1c00000c",
                     fs_to_ds_bus, inst_sram_en, inst_sram_addr);
        end
        advance();
        apply(1'b1, 1'b1, 1'b0, 32'h0);
        tests_run++;
        if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus !== {32'h1c00000c, 32'h1c00000c}) begin
            tests_failed++;
            $display("[TB] FAIL after_stall: got valid=%b bus=%h expected 1/1c00000c1c00000c",
                     fs_to_ds_valid, fs_to_ds_bus);
        end
        advance();
    endtask

    task automatic test_branch();
        apply(1'b1, 1'b1, 1'b1, 32'h1c000100);
        tests_run++;
        if (fs_to_ds_valid !== 1'b0 || inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h1c000100) begin
            tests_failed++;
            $display("[TB] FAIL branch_cycle: got valid=%b en=%b addr=%h expected 0/1/1c000100",
                     fs_to_ds_valid, inst_sram_en, inst_sram_addr);
        end
        advance();
        apply(1'b1, 1'b1, 1'b0, 32'h0);
        tests_run++;
        if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus !== {32'h1c000100, 32'h1c000100}) begin
            tests_failed++;
            $display("[TB] FAIL branch_target: got valid=%b bus=%h expected 1/1c0001001c000100",
                     fs_to_ds_valid, fs_to_ds_bus);
        end
        advance();
    endtask

    task automatic test_branch_stalled();
        // Stall so the skid buffer fills with the word at 0x1c000104.
        for (int i = 0; i < 2; i++) begin
            apply(1'b1, 1'b0, 1'b0, 32'h0);
            advance();
        end
        // Redirect held for two cycles while decode is still stalled.
        for (int i = 0; i < 2; i++) begin
            apply(1'b1, 1'b0, 1'b1, 32'h1c000200);
            tests_run++;
            if (fs_to_ds_valid !== 1'b0 || inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h1c000200) begin
                tests_failed++;
                $display("[TB] FAIL branch_stall_%0d: got valid=%b en=%b addr=%h expected 0/1/1c000200",
                         i, fs_to_ds_valid, inst_sram_en, inst_sram_addr);
            end
            advance();
        end
        apply(1'b1, 1'b0, 1'b0, 32'h0);
        tests_run++;
        if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus !== {32'h1c000200, 32'h1c000200} || inst_sram_en !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL branch_stall_fresh: got valid=%b bus=%h en=%b expected 1/1c0002001c000200/0",
                     fs_to_ds_valid, fs_to_ds_bus, inst_sram_en);
        end
        advance();
        apply(1'b1, 1'b1, 1'b0, 32'h0);
        tests_run++;
        if (fs_to_ds_bus !== {32'h1c000200, 32'h1c000200} || inst_sram_addr !== 32'h1c000204) begin
            tests_failed++;
            $display("[TB] FAIL branch_stall_handoff: got bus=%h addr=%h expected 1c0002001c000200/1c000204",
                     fs_to_ds_bus, inst_sram_addr);
        end
        advance();
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 2; i++) begin
            apply(1'b1, 1'b0, 1'b0, 32'h0);
            advance();
        end
        apply(1'b0, 1'b0, 1'b0, 32'h0);
        tests_run++;
        if (fs_to_ds_valid !== 1'b0 || inst_sram_en !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midreset: got valid=%b en=%b expected 0/0", fs_to_ds_valid, inst_sram_en);
        end
        advance();
        apply(1'b1, 1'b1, 1'b0, 32'h0);
        tests_run++;
        if (fs_to_ds_valid !== 1'b0 || inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h1c000000) begin
            tests_failed++;
            $display("[TB] FAIL midreset_restart: got valid=%b en=%b addr=%h expected 0/1/1c000000",
                     fs_to_ds_valid, inst_sram_en, inst_sram_addr);
        end
        advance();
        apply(1'b1, 1'b1, 1'b0, 32'h0);
        tests_run++;
        if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus !== {32'h1c000000, 32'h1c000000}) begin
            tests_failed++;
            $display("[TB] FAIL midreset_first: got valid=%b bus=%h expected 1/1c0000001c000000",
                     fs_to_ds_valid, fs_to_ds_bus);
        end
        advance();
    endtask

    task automatic test_wrap();
        apply(1'b1, 1'b1, 1'b1, 32'hfffffff8);
        advance();
        apply(1'b1, 1'b1, 1'b0, 32'h0);
        advance();
        apply(1'b1, 1'b1, 1'b0, 32'h0);
        tests_run++;
        if (fs_to_ds_bus !== {32'hfffffffc, 32'hfffffffc} || inst_sram_addr !== 32'h00000000) begin
            tests_failed++;
            $display("[TB] FAIL wrap: got bus=%h addr=%h expected fffffffcfffffffc/00000000",
                     fs_to_ds_bus, inst_sram_addr);
        end
        advance();
        apply(1'b1, 1'b1, 1'b0, 32'h0);
        tests_run++;
        if (fs_to_ds_bus !== 64'h0 || inst_sram_addr !== 32'h00000004) begin
            tests_failed++;
            $display("[TB] FAIL wrap_next: got bus=%h addr=%h expected 0/00000004",
                     fs_to_ds_bus, inst_sram_addr);
        end
        advance();
    endtask

    task automatic test_random();
        logic rst_n, ain, bt;
        logic [31:0] tgt;
        // New memory image, loaded while the stage is held in reset.
        key = $urandom;
        apply(1'b0, 1'b1, 1'b0, 32'h0);
        advance();
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 49) != 0);
            ain   = ($urandom_range(0, 3) != 0);
            bt    = ($urandom_range(0, 7) == 0);
            tgt   = $urandom;
            apply(rst_n, ain, bt, tgt);
            tests_run++;
            if (fs_to_ds_valid !== exp_valid) begin
                tests_failed++;
                $display("[TB] FAIL rnd_valid cyc %0d: got %b expected %b", i, fs_to_ds_valid, exp_valid);
            end
            tests_run++;
            if (inst_sram_en !== exp_en) begin
                tests_failed++;
                $display("[TB] FAIL rnd_en cyc %0d: got %b expected %b", i, inst_sram_en, exp_en);
            end
            if (exp_en) begin
                tests_run++;
                if (inst_sram_addr !== exp_addr) begin
                    tests_failed++;
                    $display("[TB] FAIL rnd_addr cyc %0d: got %h expected %h", i, inst_sram_addr, exp_addr);
                end
            end
            if (exp_valid) begin
                tests_run++;
                if (fs_to_ds_bus !== exp_bus) begin
                    tests_failed++;
                    $display("[TB] FAIL rnd_bus cyc %0d: got %h expected %h", i, fs_to_ds_bus, exp_bus);
                end
            end
            advance();
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        key          = 32'h0;
        pend_en      = 1'b0;
        pend_addr    = 32'h0;
        garbage      = 32'hdeadbeef;
        m_valid      = 1'b0;
        m_pc         = RESET_PC - 32'd4;
        cur_rst      = 1'b0;
        resetn       = 1'b0;
        ds_allowin   = 1'b1;
        br_bus       = '0;

        test_reset();
        test_stream_and_stall();
        test_branch();
        test_branch_stalled();
        test_reset_midstream();
        test_wrap();
        test_random();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the five-stage blocking LoongArch pipeline; the producing end of the fs→ds handshake and the consumer of the branch bus that the decode stage drives.
- Contains the pre-IF next-PC logic, the IF-stage valid/PC registers, the synchronous instruction-SRAM request port and a one-entry instruction skid buffer.
- The skid buffer holds SRAM read data while decode stalls on hazards.

Parameters:
- RESET_PC, 32'h1c000000, address of the first fetch after reset release.

Ports:
- clk  input  1  clock
- resetn  input  1  synchronous active-low reset
- ds_allowin  input  1  decode can accept an instruction this cycle
- br_bus  input  33  {br_taken[32], br_target[31:0]} from decode
- fs_to_ds_valid  output  1  instruction valid toward decode
- fs_to_ds_bus  output  64  {fs_inst[63:32], fs_pc[31:0]}
- inst_sram_en  output  1  fetch request strobe
- inst_sram_we  output  4  constant 4'h0
- inst_sram_addr  output  32  fetch address (nextpc)
- inst_sram_wdata  output  32  constant 32'h0
- inst_sram_rdata  input  32  read data, valid exactly one cycle after an enabled request

Behaviour:
- Reset (resetn=0 at posedge):
  - fs_valid=0, fs_pc=RESET_PC-4, buf_valid=0, inst_buf=0, rdata_fresh=0.
  - While resetn=0: inst_sram_en=0, fs_to_ds_valid=0.
- Pre-IF:
  - to_fs_valid = resetn.
  - seq_pc = fs_pc+4, 32-bit wrap.
  - nextpc = br_taken ? br_target : seq_pc.
  - inst_sram_en = to_fs_valid && fs_allowin.
  - inst_sram_addr = nextpc.
- fs_ready_go = 1.
- fs_allowin = !fs_valid || (fs_ready_go && ds_allowin) || br_taken.
  - br_taken forces a redirect fetch even when decode is stalled.
- fs_to_ds_valid = fs_valid && fs_ready_go && !br_taken.
  - The instruction in IF during a taken branch is wrong-path; decode drops it.
- On posedge, when fs_allowin: fs_valid<=to_fs_valid, fs_pc<=nextpc.
- rdata_fresh <= inst_sram_en, so it is 1 in the cycle SRAM data is valid.
- fs_inst = buf_valid ? inst_buf : inst_sram_rdata.
- Skid buffer:
  - Capture: inst_buf<=inst_sram_rdata, buf_valid<=1 when rdata_fresh && fs_valid && !ds_allowin && !buf_valid && !br_taken.
  - Clear: buf_valid<=0 when (fs_to_ds_valid && ds_allowin) or br_taken.
  - Clear has priority over capture.
- Latency:
  - Request at cycle N, fs_to_ds_valid at N+1.
  - First fetch after reset: resetn rises before edge E; en=1 with addr=RESET_PC in cycle E; fs_valid=1, fs_pc=RESET_PC in cycle E+1.
- Steady state: one instruction per cycle when ds_allowin=1.
- Decode stall: fs_pc and fs_inst stay stable, no new request (en=0), and the buffered instruction is presented until handed off.
- br_taken:
  - May be held for several cycles with a constant target; each cycle re-issues the target fetch (idempotent).
  - After the last br_taken cycle, fs_pc=br_target with fresh data.
- br_taken with fs_valid=0: the redirect still occurs.
- br_taken together with buf_valid: the buffer is discarded.
- Reset mid-operation: any in-flight SRAM response is ignored (rdata_fresh cleared) and fetch restarts at RESET_PC.
- No alignment checking; br_target is used as given.

Decomposition:
- mycpu.h shared header: FS_TO_DS_BUS_WD=64, BR_BUS_WD=33, RESET_PC default; same widths as decode uses.
- One natural sub-module: fs_inst_skid, the one-entry buffer with capture/clear/bypass mux, parameterized by data width.
- Next-PC logic and valid registers stay in if_stage.

Test Plan:
- Reset release, ds_allowin=1, SRAM returns addr as data: requests 0x1c000000, 0x1c000004, 0x1c000008 on consecutive cycles; fs_to_ds_bus = {0x1c000000,0x1c000000} one cycle after the first request; one instruction per cycle.
- Decode stalls 3 cycles with fs_pc=0x1c000008 while SRAM rdata is driven to garbage after the first cycle: inst_sram_en=0 throughout, fs_to_ds_bus holds inst 0x1c000008; on release, next request is 0x1c00000c.
- br_bus={1,0x1c000100} for one cycle with fs_valid=1 and ds_allowin=1: fs_to_ds_valid=0 that cycle, inst_sram_addr=0x1c000100; next cycle fs_pc=0x1c000100, valid=1.
- br_taken asserted while decode is stalled with buf_valid=1: buffer cleared, target fetched; afterwards fs_inst comes from SRAM at br_target, not the stale buffer.
- resetn pulled low for 1 cycle mid-stream with buf_valid=1: fs_to_ds_valid=0 and en=0 during reset; restart fetch at 0x1c000000 and no stale instruction is presented.
- fs_pc=0xfffffffc sequential: nextpc wraps to 0x00000000.
